// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and small helpers for the seven-segment
// counter monitor.
package seg7_pkg;

   localparam int ERR_W = 8;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [0:0] {
      WAIT_FIRST = 1'b0,
      TRACK      = 1'b1
   } state_t;

   function automatic logic [3:0] next_digit(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   // Error counter sticks at all-ones instead of wrapping
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == {ERR_W{1'b1}}) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/seg7_monitor_if.sv
// Pattern input / status output bundle of the seven-segment monitor.
interface seg7_monitor_if;
   import seg7_pkg::*;

   logic             ena;
   logic [6:0]       seg_in;
   logic [3:0]       digit_out;
   logic             digit_valid;
   logic             blank;
   logic             bad_pat;
   logic             seq_err;
   logic [ERR_W-1:0] error_cnt;

   modport master (
      output ena, seg_in,
      input  digit_out, digit_valid, blank, bad_pat, seq_err, error_cnt
   );

   modport slave (
      input  ena, seg_in,
      output digit_out, digit_valid, blank, bad_pat, seq_err, error_cnt
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to digit lookup with blank / valid flags.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       is_blank,
   output logic       is_valid
);

   // Exact-match lookup; anything not in the table is flagged invalid
   always_comb begin
      digit    = 4'd0;
      is_blank = 1'b0;
      is_valid = 1'b1;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: begin
            is_blank = 1'b1;
            is_valid = 1'b0;
         end
         default:   is_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_monitor.sv
// Debounces a seven-segment pattern stream and checks that accepted digits
// follow the 0..9 counting sequence, reporting glitches and sequence breaks.
module seg7_monitor
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 4
)
(
   input  logic          clk,
   input  logic          rst_n,
   seg7_monitor_if.slave mon
);

   localparam logic [3:0] STABLE_LAST = 4'(STABLE_CNT - 1);
   localparam logic [3:0] STABLE_FULL = 4'(STABLE_CNT);

   logic [6:0]       seg_q_r, seg_q_nxt_s;
   logic [3:0]       cnt_r, cnt_nxt_s;
   logic             accept_s;
   logic [3:0]       dec_digit_s;
   logic             dec_blank_s, dec_valid_s;
   state_t           state_r, state_nxt_s;
   logic [3:0]       digit_r, digit_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic             blank_r, blank_nxt_s;
   logic             bad_r, bad_nxt_s;
   logic             seq_r, seq_nxt_s;
   logic [ERR_W-1:0] err_r, err_nxt_s;

   seg7_decode u_decode (
      .seg      (seg_q_r),
      .digit    (dec_digit_s),
      .is_blank (dec_blank_s),
      .is_valid (dec_valid_s)
   );

   // Stability sampler: accept fires exactly once per stable run
   always_comb begin
      seg_q_nxt_s = seg_q_r;
      cnt_nxt_s   = cnt_r;
      accept_s    = 1'b0;
      if (mon.ena) begin
         if (mon.seg_in != seg_q_r) begin
            seg_q_nxt_s = mon.seg_in;
            cnt_nxt_s   = 4'd0;
         end else if (cnt_r == STABLE_LAST) begin
            accept_s  = 1'b1;
            cnt_nxt_s = STABLE_FULL;
         end else if (cnt_r < STABLE_FULL) begin
            cnt_nxt_s = cnt_r + 4'd1;
         end else begin
            cnt_nxt_s = cnt_r;
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Sampler registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q_r <= 7'h00;
         cnt_r   <= 4'd0;
      end else begin
         seg_q_r <= seg_q_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Sequence FSM next state and registered-output next values
   always_comb begin
      state_nxt_s = state_r;
      digit_nxt_s = digit_r;
      blank_nxt_s = blank_r;
      err_nxt_s   = err_r;
      valid_nxt_s = 1'b0;
      bad_nxt_s   = 1'b0;
      seq_nxt_s   = 1'b0;
      if (accept_s) begin
         if (dec_blank_s) begin
            blank_nxt_s = 1'b1;
            state_nxt_s = WAIT_FIRST;
         end else if (!dec_valid_s) begin
            bad_nxt_s   = 1'b1;
            blank_nxt_s = 1'b0;
            err_nxt_s   = sat_inc(err_r);
         end else begin
            blank_nxt_s = 1'b0;
            case (state_r)
               WAIT_FIRST: begin
                  digit_nxt_s = dec_digit_s;
                  valid_nxt_s = 1'b1;
                  state_nxt_s = TRACK;
               end
               TRACK: begin
                  if (dec_digit_s == next_digit(digit_r)) begin
                     digit_nxt_s = dec_digit_s;
                     valid_nxt_s = 1'b1;
                  end else if (dec_digit_s == digit_r) begin
                     // A glitch that settles back to the shown digit is benign
                     digit_nxt_s = digit_r;
                  end else begin
                     digit_nxt_s = dec_digit_s;
                     valid_nxt_s = 1'b1;
                     seq_nxt_s   = 1'b1;
                     err_nxt_s   = sat_inc(err_r);
                  end
               end
               default: state_nxt_s = WAIT_FIRST;
            endcase
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= WAIT_FIRST;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_r <= 4'd0;
         valid_r <= 1'b0;
         blank_r <= 1'b0;
         bad_r   <= 1'b0;
         seq_r   <= 1'b0;
         err_r   <= {ERR_W{1'b0}};
      end else begin
         digit_r <= digit_nxt_s;
         valid_r <= valid_nxt_s;
         blank_r <= blank_nxt_s;
         bad_r   <= bad_nxt_s;
         seq_r   <= seq_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   assign mon.digit_out   = digit_r;
   assign mon.digit_valid = valid_r;
   assign mon.blank       = blank_r;
   assign mon.bad_pat     = bad_r;
   assign mon.seq_err     = seq_r;
   assign mon.error_cnt   = err_r;

endmodule

// File: tb/tb_seg7_monitor.sv
// Self-checking bench for seg7_monitor: vector table, directed corner
// sequences and randomized stimulus against a run-length reference model.
module tb_seg7_monitor;

   localparam int STABLE = 4;

   logic clk;
   logic rst_n;

   seg7_monitor_if mon ();

   seg7_monitor #(.STABLE_CNT(STABLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (mon)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int checks = 0;
   int passes = 0;
   int n_valid, n_seq, n_bad;

   // reference model state
   logic [6:0] m_prev;
   int         m_run;
   int         m_digit;
   bit         m_track, m_blank, m_valid, m_bad, m_seq;
   int         m_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int pat2digit(input logic [6:0] p);
      if (p == 7'h00) return -2;
      for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_prev = 7'h00; m_run = 0; m_digit = 0;
      m_track = 0; m_blank = 0; m_valid = 0; m_bad = 0; m_seq = 0; m_err = 0;
   endtask

   task automatic model_accept(input logic [6:0] p);
      int d;
      d = pat2digit(p);
      if (d == -2) begin
         m_blank = 1; m_track = 0;
      end else if (d < 0) begin
         m_bad = 1; m_blank = 0;
         m_err = (m_err < 255) ? m_err + 1 : 255;
      end else begin
         m_blank = 0;
         if (!m_track) begin
            m_digit = d; m_valid = 1; m_track = 1;
         end else if (d == (m_digit + 1) % 10) begin
            m_digit = d; m_valid = 1;
         end else if (d != m_digit) begin
            m_digit = d; m_valid = 1; m_seq = 1;
            m_err = (m_err < 255) ? m_err + 1 : 255;
         end
      end
   endtask

   // a pattern is accepted when it has been seen on STABLE further enabled edges
   task automatic model_edge(input bit en, input logic [6:0] s);
      m_valid = 0; m_bad = 0; m_seq = 0;
      if (en) begin
         if (s != m_prev) begin
            m_prev = s; m_run = 0;
         end else begin
            m_run++;
            if (m_run == STABLE) model_accept(s);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(mon.ena, mon.seg_in);
      #1;
      chk("digit_out",   int'(mon.digit_out),   m_digit);
      chk("digit_valid", int'(mon.digit_valid), int'(m_valid));
      chk("blank",       int'(mon.blank),       int'(m_blank));
      chk("bad_pat",     int'(mon.bad_pat),     int'(m_bad));
      chk("seq_err",     int'(mon.seq_err),     int'(m_seq));
      chk("error_cnt",   int'(mon.error_cnt),   m_err);
      chk("bad_and_seq", int'(mon.bad_pat & mon.seq_err), 0);
      n_valid += int'(mon.digit_valid);
      n_seq   += int'(mon.seq_err);
      n_bad   += int'(mon.bad_pat);
   endtask

   task automatic hold(input logic [6:0] s, input int n);
      mon.seg_in = s;
      repeat (n) step();
   endtask

   task automatic clear_counts();
      n_valid = 0; n_seq = 0; n_bad = 0;
   endtask

   // asynchronous reset between edges; outputs must clear with no clock edge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_digit_out",   int'(mon.digit_out),   0);
      chk("rst_digit_valid", int'(mon.digit_valid), 0);
      chk("rst_blank",       int'(mon.blank),       0);
      chk("rst_bad_pat",     int'(mon.bad_pat),     0);
      chk("rst_seq_err",     int'(mon.seq_err),     0);
      chk("rst_error_cnt",   int'(mon.error_cnt),   0);
      model_reset();
      #2 rst_n = 1'b1;
   endtask

   typedef struct {
      logic [6:0] seg;
      bit         ena;
      int         cycles;
      int         e_digit, e_valid, e_seq, e_bad, e_blank, e_err;
   } vec_t;

   vec_t vecs [20];

   initial begin
      vecs[0]  = '{7'h3F, 1'b1, 10, 0, 1, 0, 0, 0, 0};
      vecs[1]  = '{7'h06, 1'b1, 10, 1, 1, 0, 0, 0, 0};
      vecs[2]  = '{7'h5B, 1'b1, 10, 2, 1, 0, 0, 0, 0};
      vecs[3]  = '{7'h4F, 1'b1, 10, 3, 1, 0, 0, 0, 0};
      vecs[4]  = '{7'h66, 1'b1, 10, 4, 1, 0, 0, 0, 0};
      vecs[5]  = '{7'h6D, 1'b1, 10, 5, 1, 0, 0, 0, 0};
      vecs[6]  = '{7'h7D, 1'b1, 10, 6, 1, 0, 0, 0, 0};
      vecs[7]  = '{7'h07, 1'b1, 10, 7, 1, 0, 0, 0, 0};
      vecs[8]  = '{7'h7F, 1'b1, 10, 8, 1, 0, 0, 0, 0};
      vecs[9]  = '{7'h6F, 1'b1, 10, 9, 1, 0, 0, 0, 0};
      vecs[10] = '{7'h3F, 1'b1, 10, 0, 1, 0, 0, 0, 0};
      vecs[11] = '{7'h4F, 1'b1, 10, 3, 1, 1, 0, 0, 1};
      vecs[12] = '{7'h49, 1'b1, 10, 3, 0, 0, 1, 0, 2};
      vecs[13] = '{7'h00, 1'b1, 10, 3, 0, 0, 0, 1, 2};
      vecs[14] = '{7'h66, 1'b1, 10, 4, 1, 0, 0, 0, 2};
      vecs[15] = '{7'h66, 1'b1, 10, 4, 0, 0, 0, 0, 2};
      vecs[16] = '{7'h6D, 1'b1,  3, 4, 0, 0, 0, 0, 2};
      vecs[17] = '{7'h6D, 1'b1, 10, 5, 1, 0, 0, 0, 2};
      vecs[18] = '{7'h7D, 1'b0, 10, 5, 0, 0, 0, 0, 2};
      vecs[19] = '{7'h7D, 1'b1, 10, 6, 1, 0, 0, 0, 2};

      rst_n = 1'b0;
      mon.ena = 1'b1;
      mon.seg_in = 7'h00;
      model_reset();
      #12;
      chk("por_digit_out", int'(mon.digit_out), 0);
      chk("por_error_cnt", int'(mon.error_cnt), 0);
      rst_n = 1'b1;

      // vector table
      for (int i = 0; i < 20; i++) begin
         clear_counts();
         mon.ena = vecs[i].ena;
         hold(vecs[i].seg, vecs[i].cycles);
         chk($sformatf("vec%0d_digit", i), int'(mon.digit_out), vecs[i].e_digit);
         chk($sformatf("vec%0d_nvalid", i), n_valid, vecs[i].e_valid);
         chk($sformatf("vec%0d_nseq", i), n_seq, vecs[i].e_seq);
         chk($sformatf("vec%0d_nbad", i), n_bad, vecs[i].e_bad);
         chk($sformatf("vec%0d_blank", i), int'(mon.blank), vecs[i].e_blank);
         chk($sformatf("vec%0d_err", i), int'(mon.error_cnt), vecs[i].e_err);
      end
      mon.ena = 1'b1;

      // first acceptance latency: visible after the fifth edge
      do_reset();
      mon.seg_in = 7'h3F;
      for (int i = 0; i < STABLE; i++) begin
         step();
         chk("lat_early_valid", int'(mon.digit_valid), 0);
      end
      step();
      chk("lat_valid", int'(mon.digit_valid), 1);
      chk("lat_digit", int'(mon.digit_out), 0);
      step();
      chk("lat_single", int'(mon.digit_valid), 0);
      chk("lat_err", int'(mon.error_cnt), 0);

      // glitch that returns to the displayed digit
      do_reset();
      hold(7'h06, 10);
      clear_counts();
      hold(7'h7F, 2);
      hold(7'h06, 10);
      chk("glitch_nvalid", n_valid, 0);
      chk("glitch_err", int'(mon.error_cnt), 0);
      chk("glitch_digit", int'(mon.digit_out), 1);

      // invalid pattern and error counter saturation
      do_reset();
      clear_counts();
      hold(7'h49, 10);
      chk("bad_once", n_bad, 1);
      clear_counts();
      for (int i = 0; i < 300; i++) begin
         hold(7'h00, 5);
         hold(7'h49, 5);
      end
      chk("sat_nbad", n_bad, 300);
      chk("sat_err", int'(mon.error_cnt), 255);

      // reset in the middle of a hold, then blank and a fresh digit
      do_reset();
      hold(7'h06, 10);
      mon.seg_in = 7'h5B;
      step(); step();
      do_reset();
      clear_counts();
      hold(7'h00, 10);
      chk("post_rst_blank", int'(mon.blank), 1);
      hold(7'h6D, 10);
      chk("post_rst_nvalid", n_valid, 1);
      chk("post_rst_nseq", n_seq, 0);
      chk("post_rst_digit", int'(mon.digit_out), 5);

      // randomized stimulus against the model
      begin
         int cur;
         cur = 0;
         for (int i = 0; i < 300; i++) begin
            int r;
            logic [6:0] p;
            r = int'($urandom_range(0, 9));
            if (r < 6)       begin cur = (cur + 1) % 10; p = pats[cur]; end
            else if (r == 6) p = pats[cur];
            else if (r == 7) p = 7'h00;
            else if (r == 8) begin cur = int'($urandom_range(0, 9)); p = pats[cur]; end
            else             p = 7'($urandom);
            mon.ena = ($urandom_range(0, 9) != 0);
            hold(p, int'($urandom_range(1, 8)));
            if ($urandom_range(0, 49) == 0) do_reset();
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
